tdc_readout_merger: RTL and testbench
=====================================

// Module: tdc_readout_merger
// PURPOSE
//  Downstream stage of the two TDC data channels. Merges their DPRAM write streams
//  into one shared IPbus RAM port.
//  Each stream (data, 8-bit address, we) is buffered in its own FIFO and drained by a
//  round-robin arbiter, one write per SYSCLK.
//  The channel number is prepended to the RAM address. Overflow is flagged per channel.
// PARAMETERS
//  FIFO_DEPTH  16  entries per channel FIFO; power of 2, >= 4
//  LVL_W       5   level width = log2(FIFO_DEPTH)+1
// PORTS
//  SYSCLK        in   1      system clock; all logic on rising edge
//  RESET         in   1      synchronous, active-high reset
//  ch1_data      in   32     channel 1 RAM write data
//  ch1_address   in   8      channel 1 RAM write address
//  ch1_we        in   1      channel 1 write strobe; one word per high cycle
//  ch2_data      in   32     channel 2 RAM write data
//  ch2_address   in   8      channel 2 RAM write address
//  ch2_we        in   1      channel 2 write strobe
//  ram_data      out  32     merged RAM write data
//  ram_address   out  9      {channel_id, address}; ch1 -> 0, ch2 -> 1
//  ram_we        out  1      merged RAM write strobe
//  ch1_level     out  LVL_W  channel 1 FIFO occupancy
//  ch2_level     out  LVL_W  channel 2 FIFO occupancy
//  ch1_overflow  out  1      sticky: a channel 1 word was dropped
//  ch2_overflow  out  1      sticky: a channel 2 word was dropped
//  overflow_clr  in   1      single-cycle clear of both sticky flags and the drop counters
// BEHAVIOUR
//  Reset: all outputs 0, FIFOs emptied, last_grant = ch2, so ch1 wins the first tie.
//   Buffered words are discarded. RESET overrides every other input in the same cycle.
//  Push: when chN_we = 1 and the FIFO is not full, {address, data} is written at the edge.
//   Full is taken from the registered level; there is no same-cycle pop bypass.
//  Drop: chN_we = 1 while full -> the word is discarded and chN_overflow is set at that edge.
//   If overflow_clr coincides with a drop, the flag ends up set (set wins).
//  Arbiter (per cycle, registered levels):
//   - neither FIFO non-empty: idle, ram_we = 0 next cycle;
//   - one non-empty: that FIFO is popped;
//   - both non-empty: the channel that is not last_grant is popped, then last_grant updates.
//  Output register: the popped entry loads ram_data/ram_address/ram_we at the same edge
//   as the pop. ram_we = 0 on idle cycles; ram_data/ram_address hold their last value.
//  Latency: ch_we sampled at edge k -> ram_we high in the cycle after edge k+1
//   (2 edges, empty FIFO, no contention).
//  Throughput: 1 word/cycle total. With both channels writing every cycle, each channel
//   is drained at 1/2 rate, and the FIFOs fill and drop.
//  Ordering: strictly FIFO per channel. No ordering across channels.
//  Level: push and pop in the same cycle leaves the level unchanged.
//   Range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  TDC_MERGER_DROPCNT_EN defined:
//   - adds outputs ch1_drop_count[15:0] and ch2_drop_count[15:0];
//   - each counter increments once per dropped word and saturates at 16'hFFFF;
//   - cleared by RESET or overflow_clr; a drop in the clear cycle gives count = 1.
//  Undefined: these ports and counters do not exist. Only the sticky flags report loss.
// TESTING
//  1) Reset, single ch1_we data=0xDEADBEEF addr=0x12 -> 2 edges later ram_we=1 for 1 cycle,
//     ram_address=0x012, ram_data=0xDEADBEEF.
//  2) ch1 and ch2 each write 3 words in the same cycles (addr 0..2) -> ram_address sequence
//     0x000,0x100,0x001,0x101,0x002,0x102 on 6 consecutive cycles.
//  3) Hold the FIFO full: ch1_we for 40 cycles while ch2 writes every cycle -> ch1_level
//     peaks at 16, ch1_overflow=1. With DROPCNT_EN, ch1_drop_count equals the pushes
//     refused. Order of accepted words is preserved.
//  4) Assert RESET while both FIFOs hold 10 words -> next cycle levels=0, ram_we=0,
//     flags=0. The next single ch2 write appears with ram_address=0x1xx after 2 edges.
//  5) overflow_clr and a drop on ch2 in the same cycle -> ch2_overflow=1.
//     With DROPCNT_EN, ch2_drop_count=1.
//  6) Push and pop of ch1 in the same cycle at level 8 -> level stays 8.
//     A push at level 16 with a simultaneous pop is dropped and the level becomes 15.

Source files
------------

// File: rtl/tdc_readout_merger.sv
// tdc_readout_merger
// Downstream stage of the two TDC data channels. Each channel's DPRAM write stream
// is buffered in its own FIFO and the two FIFOs are drained round-robin into one
// shared IPbus RAM port, one write per SYSCLK. The channel number becomes the MSB
// of the RAM address (ch1 -> 0, ch2 -> 1). Words arriving at a full FIFO are
// dropped and flagged with a sticky per-channel overflow bit.
// Optional feature: define TDC_MERGER_DROPCNT_EN to add saturating 16-bit
// per-channel drop counters (ch1_drop_count / ch2_drop_count).

module tdc_readout_merger #(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic             SYSCLK,
    input  logic             RESET,
    input  logic [31:0]      ch1_data,
    input  logic [7:0]       ch1_address,
    input  logic             ch1_we,
    input  logic [31:0]      ch2_data,
    input  logic [7:0]       ch2_address,
    input  logic             ch2_we,
    output logic [31:0]      ram_data,
    output logic [8:0]       ram_address,
    output logic             ram_we,
    output logic [LVL_W-1:0] ch1_level,
    output logic [LVL_W-1:0] ch2_level,
    output logic             ch1_overflow,
    output logic             ch2_overflow,
`ifdef TDC_MERGER_DROPCNT_EN
    output logic [15:0]      ch1_drop_count,
    output logic [15:0]      ch2_drop_count,
`endif
    input  logic             overflow_clr
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        GRANT_CH1 = 1'b0,
        GRANT_CH2 = 1'b1
    } grant_t;

    grant_t           last_grant;

    logic [39:0]      in_word [2];
    logic [1:0]       in_we;
    logic [LVL_W-1:0] level [2];
    logic [39:0]      head [2];
    logic [1:0]       overflow;
    logic [1:0]       full;
    logic [1:0]       non_empty;
    logic [1:0]       push;
    logic [1:0]       drop;
    logic [1:0]       pop;

    assign in_word[0] = {ch1_address, ch1_data};
    assign in_word[1] = {ch2_address, ch2_data};
    assign in_we      = {ch2_we, ch1_we};

    // Full/empty come from the registered level only, so a pop never frees room for a same-cycle push
    always_comb begin
        full      = '0;
        non_empty = '0;
        push      = '0;
        drop      = '0;
        full[0]      = (level[0] == FULL_LEVEL);
        full[1]      = (level[1] == FULL_LEVEL);
        non_empty[0] = (level[0] != '0);
        non_empty[1] = (level[1] != '0);
        push         = in_we & ~full;
        drop         = in_we & full;
    end

    // Round-robin pick: a lone non-empty FIFO always wins, a tie goes to the channel not granted last
    always_comb begin
        pop = '0;
        if (non_empty[0] && (!non_empty[1] || last_grant == GRANT_CH2)) begin
            pop[0] = 1'b1;
        end else if (non_empty[1]) begin
            pop[1] = 1'b1;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic [39:0]      mem [FIFO_DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [LVL_W-1:0] level_q;
        logic             overflow_q;

        // Storage write; contents need no reset because the pointers decide what is valid
        always_ff @(posedge SYSCLK) begin
            if (push[c]) begin
                mem[wr_ptr] <= in_word[c];
            end
        end

        // Pointer and occupancy bookkeeping; push and pop together leave the level unchanged
        always_ff @(posedge SYSCLK) begin
            if (RESET) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (push[c]) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop[c]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push[c], pop[c]})
                    2'b10:   level_q <= level_q + LVL_W'(1);
                    2'b01:   level_q <= level_q - LVL_W'(1);
                    default: level_q <= level_q;
                endcase
            end
        end

        // Sticky loss flag; a drop in the clear cycle still leaves the flag set
        always_ff @(posedge SYSCLK) begin
            if (RESET) begin
                overflow_q <= 1'b0;
            end else if (drop[c]) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end

        assign level[c]    = level_q;
        assign head[c]     = mem[rd_ptr];
        assign overflow[c] = overflow_q;
    end

    // Arbiter state and output register: the popped entry is loaded at the same edge as the pop
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            last_grant  <= GRANT_CH2;
            ram_we      <= 1'b0;
            ram_data    <= '0;
            ram_address <= '0;
        end else begin
            ram_we <= |pop;
            if (pop[0]) begin
                ram_data    <= head[0][31:0];
                ram_address <= {1'b0, head[0][39:32]};
            end else if (pop[1]) begin
                ram_data    <= head[1][31:0];
                ram_address <= {1'b1, head[1][39:32]};
            end
            if (&non_empty) begin
                last_grant <= pop[0] ? GRANT_CH1 : GRANT_CH2;
            end
        end
    end

    assign ch1_level    = level[0];
    assign ch2_level    = level[1];
    assign ch1_overflow = overflow[0];
    assign ch2_overflow = overflow[1];

`ifdef TDC_MERGER_DROPCNT_EN
    logic [15:0] drop_count [2];

    // Saturating drop counters; clearing restarts the count, so a drop in the clear cycle reads 1
    always_ff @(posedge SYSCLK) begin
        for (int c = 0; c < 2; c++) begin
            if (RESET) begin
                drop_count[c] <= '0;
            end else if (overflow_clr) begin
                drop_count[c] <= drop[c] ? 16'd1 : 16'd0;
            end else if (drop[c] && drop_count[c] != 16'hFFFF) begin
                drop_count[c] <= drop_count[c] + 16'd1;
            end
        end
    end

    assign ch1_drop_count = drop_count[0];
    assign ch2_drop_count = drop_count[1];
`else
    // Without the counters, the sticky flags are the only report of lost words.
`endif

endmodule

// File: tb/tb_tdc_readout_merger.sv
// tb_tdc_readout_merger
// Directed bench for tdc_readout_merger: reset state, single-word latency,
// round-robin interleave, FIFO fill/drop with ordering, reset while loaded,
// overflow clear racing a drop, and level behaviour on push+pop.

module tb_tdc_readout_merger;

    logic        SYSCLK;
    logic        RESET;
    logic [31:0] ch1_data;
    logic [7:0]  ch1_address;
    logic        ch1_we;
    logic [31:0] ch2_data;
    logic [7:0]  ch2_address;
    logic        ch2_we;
    logic [31:0] ram_data;
    logic [8:0]  ram_address;
    logic        ram_we;
    logic [4:0]  ch1_level;
    logic [4:0]  ch2_level;
    logic        ch1_overflow;
    logic        ch2_overflow;
    logic        overflow_clr;
`ifdef TDC_MERGER_DROPCNT_EN
    logic [15:0] ch1_drop_count;
    logic [15:0] ch2_drop_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] got_ch1 [$];
    logic [31:0] exp_ch1 [$];

    tdc_readout_merger #(
        .FIFO_DEPTH (16),
        .LVL_W      (5)
    ) dut (
        .SYSCLK         (SYSCLK),
        .RESET          (RESET),
        .ch1_data       (ch1_data),
        .ch1_address    (ch1_address),
        .ch1_we         (ch1_we),
        .ch2_data       (ch2_data),
        .ch2_address    (ch2_address),
        .ch2_we         (ch2_we),
        .ram_data       (ram_data),
        .ram_address    (ram_address),
        .ram_we         (ram_we),
        .ch1_level      (ch1_level),
        .ch2_level      (ch2_level),
        .ch1_overflow   (ch1_overflow),
        .ch2_overflow   (ch2_overflow),
`ifdef TDC_MERGER_DROPCNT_EN
        .ch1_drop_count (ch1_drop_count),
        .ch2_drop_count (ch2_drop_count),
`endif
        .overflow_clr   (overflow_clr)
    );

    // Free-running 10 ns clock
    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    // Advance one rising edge and settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic w1, input logic [31:0] d1, input logic [7:0] a1,
                                 input logic w2, input logic [31:0] d2, input logic [7:0] a2,
                                 input logic clr);
        ch1_we       = w1;
        ch1_data     = d1;
        ch1_address  = a1;
        ch2_we       = w2;
        ch2_data     = d2;
        ch2_address  = a2;
        overflow_clr = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic capture();
        if (ram_we === 1'b1 && ram_address[8] === 1'b0) got_ch1.push_back(ram_data);
    endtask

    // Linear sequence of directed steps
    initial begin
        RESET = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        tick();
        doReset();
        $display("[TB] reset state");
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_data", ram_data, 0);
        checkOutput("rst_ram_address", ram_address, 0);
        checkOutput("rst_ch1_level", ch1_level, 0);
        checkOutput("rst_ch2_level", ch2_level, 0);
        checkOutput("rst_ch1_overflow", ch1_overflow, 0);
        checkOutput("rst_ch2_overflow", ch2_overflow, 0);

        // Single ch1 word: pushed at the first edge, on the RAM port after the second
        $display("[TB] single word latency");
        applyStimulus(1'b1, 32'hDEADBEEF, 8'h12, 1'b0, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("t1_we_edge1", ram_we, 0);
        checkOutput("t1_level_edge1", ch1_level, 1);
        tick();
        checkOutput("t1_we_edge2", ram_we, 1);
        checkOutput("t1_addr", ram_address, 9'h012);
        checkOutput("t1_data", ram_data, 32'hDEADBEEF);
        checkOutput("t1_level_edge2", ch1_level, 0);
        tick();
        checkOutput("t1_we_idle", ram_we, 0);
        checkOutput("t1_data_hold", ram_data, 32'hDEADBEEF);
        checkOutput("t1_addr_hold", ram_address, 9'h012);

        // Both channels write 3 words together: strict alternation starting with ch1
        $display("[TB] round-robin interleave");
        doReset();
        begin
            logic [8:0]  exp_addr [6];
            logic [31:0] exp_data [6];
            exp_addr = '{9'h000, 9'h100, 9'h001, 9'h101, 9'h002, 9'h102};
            exp_data = '{32'h1000, 32'h2000, 32'h1001, 32'h2001, 32'h1002, 32'h2002};
            for (int i = 0; i < 3; i++) begin
                applyStimulus(1'b1, 32'h1000 + 32'(i), 8'(i), 1'b1, 32'h2000 + 32'(i), 8'(i), 1'b0);
                tick();
                if (i > 0) begin
                    checkOutput($sformatf("t2_we_%0d", i - 1), ram_we, 1);
                    checkOutput($sformatf("t2_addr_%0d", i - 1), ram_address, exp_addr[i - 1]);
                    checkOutput($sformatf("t2_data_%0d", i - 1), ram_data, exp_data[i - 1]);
                end
            end
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
            for (int j = 2; j < 6; j++) begin
                tick();
                checkOutput($sformatf("t2_we_%0d", j), ram_we, 1);
                checkOutput($sformatf("t2_addr_%0d", j), ram_address, exp_addr[j]);
                checkOutput($sformatf("t2_data_%0d", j), ram_data, exp_data[j]);
            end
            tick();
            checkOutput("t2_we_done", ram_we, 0);
        end

        // Both write for 40 cycles; ch1 is popped on odd edges, so it reaches 16 after edge 30
        // and refuses the words of edges 31,33,35,37,39. ch2 fills one edge earlier.
        $display("[TB] fill, drop and ordering");
        doReset();
        got_ch1.delete();
        exp_ch1.delete();
        for (int i = 0; i < 40; i++) begin
            if (i <= 30 || (i % 2) == 0) exp_ch1.push_back(32'hA0000000 | 32'(i));
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 32'hA0000000 | 32'(i), 8'(i), 1'b1, 32'hB0000000 | 32'(i), 8'(i), 1'b0);
            tick();
            capture();
            if (i == 14) checkOutput("t6_level8_before", ch1_level, 8);
            if (i == 15) checkOutput("t6_level8_pushpop", ch1_level, 8);
            if (i == 29) begin
                checkOutput("t3_ch2_level_full", ch2_level, 16);
                checkOutput("t3_ch2_ovf_before", ch2_overflow, 0);
            end
            if (i == 30) begin
                checkOutput("t3_ch1_level_peak", ch1_level, 16);
                checkOutput("t3_ch1_ovf_before", ch1_overflow, 0);
                checkOutput("t3_ch2_ovf_set", ch2_overflow, 1);
                checkOutput("t3_ch2_level_droppop", ch2_level, 15);
            end
            if (i == 31) begin
                checkOutput("t6_level_droppop", ch1_level, 15);
                checkOutput("t3_ch1_ovf_set", ch1_overflow, 1);
            end
        end
`ifdef TDC_MERGER_DROPCNT_EN
        checkOutput("t3_ch1_drop_count", ch1_drop_count, 5);
        checkOutput("t3_ch2_drop_count", ch2_drop_count, 5);
`endif
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            tick();
            capture();
        end
        checkOutput("t3_drained_ch1", ch1_level, 0);
        checkOutput("t3_drained_ch2", ch2_level, 0);
        checkOutput("t3_ch1_count", 40'(got_ch1.size()), 40'(exp_ch1.size()));
        for (int k = 0; k < exp_ch1.size(); k++) begin
            if (k < got_ch1.size()) checkOutput($sformatf("t3_order_%0d", k), got_ch1[k], exp_ch1[k]);
        end

        // Load both FIFOs to 10 words, then reset with writes still asserted
        $display("[TB] reset while loaded");
        checkOutput("t4_ch1_ovf_pre", ch1_overflow, 1);
        checkOutput("t4_ch2_ovf_pre", ch2_overflow, 1);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b1, 32'hC0000000 | 32'(i), 8'(i), 1'b1, 32'hD0000000 | 32'(i), 8'(i), 1'b0);
            tick();
        end
        checkOutput("t4_ch1_level10", ch1_level, 10);
        checkOutput("t4_ch2_level10", ch2_level, 10);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("t4_ch1_level", ch1_level, 0);
        checkOutput("t4_ch2_level", ch2_level, 0);
        checkOutput("t4_ram_we", ram_we, 0);
        checkOutput("t4_ch1_ovf", ch1_overflow, 0);
        checkOutput("t4_ch2_ovf", ch2_overflow, 0);
        tick();
        checkOutput("t4_idle_we", ram_we, 0);
        applyStimulus(1'b0, '0, '0, 1'b1, 32'h000055AA, 8'h34, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("t4_we_edge1", ram_we, 0);
        checkOutput("t4_ch2_level1", ch2_level, 1);
        tick();
        checkOutput("t4_we_edge2", ram_we, 1);
        checkOutput("t4_addr", ram_address, 9'h134);
        checkOutput("t4_data", ram_data, 32'h000055AA);
        tick();
        checkOutput("t4_we_after", ram_we, 0);
        checkOutput("t4_ch1_empty", ch1_level, 0);

        // Same fill pattern; clear at edge 32 races a ch2 drop but not a ch1 drop
        $display("[TB] clear versus drop");
        doReset();
        for (int i = 0; i < 33; i++) begin
            applyStimulus(1'b1, 32'(i), 8'(i), 1'b1, 32'(i), 8'(i), (i == 32) ? 1'b1 : 1'b0);
            tick();
            if (i == 30) begin
                checkOutput("t5_ch2_ovf_first", ch2_overflow, 1);
`ifdef TDC_MERGER_DROPCNT_EN
                checkOutput("t5_ch2_cnt_first", ch2_drop_count, 1);
`endif
            end
            if (i == 31) begin
                checkOutput("t5_ch1_ovf_set", ch1_overflow, 1);
`ifdef TDC_MERGER_DROPCNT_EN
                checkOutput("t5_ch1_cnt_set", ch1_drop_count, 1);
`endif
            end
        end
        checkOutput("t5_ch2_ovf_setwins", ch2_overflow, 1);
        checkOutput("t5_ch1_ovf_cleared", ch1_overflow, 0);
`ifdef TDC_MERGER_DROPCNT_EN
        checkOutput("t5_ch2_cnt_restart", ch2_drop_count, 1);
        checkOutput("t5_ch1_cnt_cleared", ch1_drop_count, 0);
`endif
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("t5_ch2_ovf_clr", ch2_overflow, 0);
        checkOutput("t5_ch1_ovf_clr", ch1_overflow, 0);
`ifdef TDC_MERGER_DROPCNT_EN
        checkOutput("t5_ch2_cnt_clr", ch2_drop_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
